// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter, the two cache fill ports, the store path and the memory.
// Handshake: a request (i_req, d_req, d_wr_req) is held high until its done/ack pulse; the arbiter samples requests only while idle.
interface mem_arbiter_if #(
  parameter int WORDS = 8
);
  localparam int IW = $clog2(WORDS);

  logic          i_req;
  logic [15:0]   i_addr;
  logic          d_req;
  logic [15:0]   d_addr;
  logic          d_wr_req;
  logic [15:0]   d_wr_addr;
  logic [15:0]   d_wr_data;
  logic          mem_en;
  logic          mem_wr;
  logic [15:0]   mem_addr;
  logic [15:0]   mem_wdata;
  logic [15:0]   mem_rdata;
  logic          mem_valid;
  logic [15:0]   fill_data;
  logic [IW-1:0] fill_word;
  logic          i_fill_we;
  logic          d_fill_we;
  logic          i_done;
  logic          d_done;
  logic          d_wr_ack;
  logic          busy;
  logic [1:0]    fsm_state;

  modport master (
    input  i_req, i_addr, d_req, d_addr, d_wr_req, d_wr_addr, d_wr_data,
    input  mem_rdata, mem_valid,
    output mem_en, mem_wr, mem_addr, mem_wdata,
    output fill_data, fill_word, i_fill_we, d_fill_we,
    output i_done, d_done, d_wr_ack, busy, fsm_state
  );

  modport slave (
    output i_req, i_addr, d_req, d_addr, d_wr_req, d_wr_addr, d_wr_data,
    output mem_rdata, mem_valid,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    input  fill_data, fill_word, i_fill_we, d_fill_we,
    input  i_done, d_done, d_wr_ack, busy, fsm_state
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fixed-priority sequencer for the shared multi-cycle memory: stores, then D fills, then I fills.
// Fills issue WORDS back-to-back reads and steer the returning beats to the owning cache.
module mem_arbiter #(
  parameter int MEM_LAT = 4,
  parameter int WORDS   = 8
) (
  input  logic clk,
  input  logic rst,
  mem_arbiter_if.master bus
);
  localparam int IW = $clog2(WORDS);
  localparam int BW = 15 - IW;
  localparam logic [IW:0]   N_WORDS   = (IW+1)'(WORDS);
  localparam logic [IW-1:0] LAST_BEAT = IW'(WORDS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] FILL  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  if (MEM_LAT < 1) begin : g_bad_lat
    $error("mem_arbiter: MEM_LAT must be at least 1");
  end

  logic [1:0]    state;
  logic          owner;
  logic [BW-1:0] base;
  logic [IW:0]   issue_cnt;
  logic [IW-1:0] recv_cnt;
  logic          issuing;
  logic          beat;

  assign issuing = (state == FILL) && (issue_cnt < N_WORDS);
  // A return strobe only counts as a beat while a fill owns the memory.
  assign beat    = (state == FILL) && bus.mem_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_I;
      base      <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.d_wr_req) begin
            state <= WRITE;
          end else if (bus.d_req || bus.i_req) begin
            state     <= FILL;
            owner     <= bus.d_req ? OWN_D : OWN_I;
            base      <= bus.d_req ? bus.d_addr[15:16-BW] : bus.i_addr[15:16-BW];
            issue_cnt <= '0;
            recv_cnt  <= '0;
          end
        end
        WRITE: state <= IDLE;
        FILL: begin
          if (issuing) issue_cnt <= issue_cnt + 1'b1;
          if (beat) begin
            recv_cnt <= recv_cnt + 1'b1;
            if (recv_cnt == LAST_BEAT) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.fill_word = '0;
    bus.i_fill_we = 1'b0;
    bus.d_fill_we = 1'b0;
    bus.i_done    = 1'b0;
    bus.d_done    = 1'b0;
    bus.d_wr_ack  = 1'b0;
    case (state)
      WRITE: begin
        bus.mem_en    = 1'b1;
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = bus.d_wr_addr;
        bus.mem_wdata = bus.d_wr_data;
        bus.d_wr_ack  = 1'b1;
      end
      FILL: begin
        if (issuing) begin
          bus.mem_en   = 1'b1;
          bus.mem_addr = {base, issue_cnt[IW-1:0], 1'b0};
        end
        if (beat) begin
          bus.fill_word = recv_cnt;
          bus.i_fill_we = (owner == OWN_I);
          bus.d_fill_we = (owner == OWN_D);
        end
      end
      DONE: begin
        bus.i_done = (owner == OWN_I);
        bus.d_done = (owner == OWN_D);
      end
      default: ;
    endcase
  end

  assign bus.fill_data = bus.mem_rdata;
  assign bus.busy      = (state != IDLE);
  assign bus.fsm_state = state;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a pipelined memory model (word at a reads a^0x5A5A unless stored).
module tb_mem_arbiter;
  localparam int MEM_LAT = 4;
  localparam int WORDS   = 8;
  localparam int DONE_C  = WORDS + MEM_LAT + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_FILL  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_valid = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_q[$];
  logic [15:0] exp_store[int];

  mem_arbiter_if #(.WORDS(WORDS)) bus ();

  mem_arbiter #(.MEM_LAT(MEM_LAT), .WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [15:0] wmem   [0:65535];
  bit          wvalid [0:65535];
  logic [MEM_LAT-1:0] vpipe;
  logic [15:0]        apipe [MEM_LAT];
  logic [15:0]        ra;

  always @(posedge clk) begin
    if (rst) begin
      vpipe <= '0;
    end else begin
      vpipe[0] <= bus.mem_en & ~bus.mem_wr;
      apipe[0] <= bus.mem_addr;
      for (int i = 1; i < MEM_LAT; i++) begin
        vpipe[i] <= vpipe[i-1];
        apipe[i] <= apipe[i-1];
      end
      if (bus.mem_en && bus.mem_wr) begin
        wmem[bus.mem_addr]   <= bus.mem_wdata;
        wvalid[bus.mem_addr] <= 1'b1;
      end
    end
  end

  assign ra            = apipe[MEM_LAT-1];
  assign bus.mem_valid = vpipe[MEM_LAT-1] | force_valid;
  assign bus.mem_rdata = wvalid[ra] ? wmem[ra] : (ra ^ 16'h5A5A);

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_rd(input logic [15:0] a);
    if (exp_store.exists(int'(a))) return exp_store[int'(a)];
    return a ^ 16'h5A5A;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, " state"},     bus.fsm_state, S_IDLE);
    check({tag, " busy"},      bus.busy, 0);
    check({tag, " mem_en"},    bus.mem_en, 0);
    check({tag, " mem_wr"},    bus.mem_wr, 0);
    check({tag, " mem_addr"},  bus.mem_addr, 0);
    check({tag, " mem_wdata"}, bus.mem_wdata, 0);
    check({tag, " fill_word"}, bus.fill_word, 0);
    check({tag, " i_fill_we"}, bus.i_fill_we, 0);
    check({tag, " d_fill_we"}, bus.d_fill_we, 0);
    check({tag, " i_done"},    bus.i_done, 0);
    check({tag, " d_done"},    bus.d_done, 0);
    check({tag, " d_wr_ack"},  bus.d_wr_ack, 0);
  endtask

  // c counts cycles after the IDLE cycle that sampled the request.
  task automatic fill_cycle_checks(input bit is_d, input logic [15:0] addr, input int c);
    bit iss, bt, dn;
    logic [1:0] es;
    string t;
    t   = $sformatf("%s c%0d", is_d ? "dfill" : "ifill", c);
    iss = (c >= 1) && (c <= WORDS);
    bt  = (c >= 1 + MEM_LAT) && (c <= WORDS + MEM_LAT);
    dn  = (c == DONE_C);
    es  = (c > DONE_C) ? S_IDLE : (dn ? S_DONE : S_FILL);
    check({t, " state"},  bus.fsm_state, es);
    check({t, " busy"},   bus.busy, c <= DONE_C);
    check({t, " mem_en"}, bus.mem_en, iss);
    check({t, " mem_wr"}, bus.mem_wr, 0);
    if (iss) check({t, " mem_addr"}, bus.mem_addr, {addr[15:4], 4'h0} + 16'(2 * (c - 1)));
    check({t, " i_fill_we"}, bus.i_fill_we, bt && !is_d);
    check({t, " d_fill_we"}, bus.d_fill_we, bt && is_d);
    if (bt) begin
      check({t, " fill_word"}, bus.fill_word, c - 1 - MEM_LAT);
      check({t, " exp_q_depth"}, exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check({t, " fill_data"}, bus.fill_data, exp_q.pop_front());
    end
    check({t, " i_done"},   bus.i_done, dn && !is_d);
    check({t, " d_done"},   bus.d_done, dn && is_d);
    check({t, " d_wr_ack"}, bus.d_wr_ack, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_fill(input bit is_d, input logic [15:0] addr);
    for (int k = 0; k < WORDS; k++) exp_q.push_back(exp_rd({addr[15:4], 4'h0} + 16'(2 * k)));
    for (int c = 1; c <= DONE_C + 1; c++) begin
      @(negedge clk);
      fill_cycle_checks(is_d, addr, c);
      if (c == DONE_C) begin
        if (is_d) bus.d_req = 1'b0;
        else      bus.i_req = 1'b0;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_addr = 0;
    bus.d_wr_req = 0; bus.d_wr_addr = 0; bus.d_wr_data = 0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // single I fill of block 0x0120, spot-checking the first and last beat by hand
    bus.i_req = 1; bus.i_addr = 16'h012A;
    for (int k = 0; k < WORDS; k++) exp_q.push_back(exp_rd(16'h0120 + 16'(2 * k)));
    for (int c = 1; c <= DONE_C + 1; c++) begin
      @(negedge clk);
      if (c == 5)  check("ifill beat0 data", bus.fill_data, 16'h5B7A);
      if (c == 12) check("ifill beat7 data", bus.fill_data, 16'h5B74);
      fill_cycle_checks(1'b0, 16'h012A, c);
      if (c == DONE_C) bus.i_req = 0;
    end

    // stray return strobe while idle
    force_valid = 1'b1;
    #1;
    check("idle valid i_fill_we", bus.i_fill_we, 0);
    check("idle valid d_fill_we", bus.d_fill_we, 0);
    check("idle valid busy",      bus.busy, 0);
    @(negedge clk);
    force_valid = 1'b0;
    check("idle valid state", bus.fsm_state, S_IDLE);

    // I and D together: D first, I granted in the IDLE cycle after d_done
    bus.i_req = 1; bus.i_addr = 16'h0A00;
    bus.d_req = 1; bus.d_addr = 16'h4000;
    run_fill(1'b1, 16'h4000);
    check("i pending after d", bus.i_req, 1);
    run_fill(1'b0, 16'h0A00);

    // store beats the concurrent D fill, which then reads the stored word back
    bus.d_wr_req = 1; bus.d_wr_addr = 16'h0010; bus.d_wr_data = 16'hBEEF;
    bus.d_req = 1; bus.d_addr = 16'h0010;
    exp_store[16'h0010] = 16'hBEEF;
    @(negedge clk);
    check("wr state",     bus.fsm_state, S_WRITE);
    check("wr mem_en",    bus.mem_en, 1);
    check("wr mem_wr",    bus.mem_wr, 1);
    check("wr mem_addr",  bus.mem_addr, 16'h0010);
    check("wr mem_wdata", bus.mem_wdata, 16'hBEEF);
    check("wr ack",       bus.d_wr_ack, 1);
    check("wr d_fill_we", bus.d_fill_we, 0);
    bus.d_wr_req = 0;
    @(negedge clk);
    check("wr after state",  bus.fsm_state, S_IDLE);
    check("wr after ack",    bus.d_wr_ack, 0);
    check("wr after mem_en", bus.mem_en, 0);
    run_fill(1'b1, 16'h0010);

    // reset in cycle 7 of a fill aborts it without a done pulse
    bus.i_req = 1; bus.i_addr = 16'h0200;
    for (int k = 0; k < WORDS; k++) exp_q.push_back(exp_rd(16'h0200 + 16'(2 * k)));
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      fill_cycle_checks(1'b0, 16'h0200, c);
    end
    rst = 1'b1; bus.i_req = 0;
    exp_q.delete();
    @(negedge clk);
    check_idle_outputs("abort c8");
    rst = 1'b0;
    for (int c = 9; c <= 16; c++) begin
      @(negedge clk);
      check($sformatf("abort c%0d i_done", c), bus.i_done, 0);
      check($sformatf("abort c%0d i_fill_we", c), bus.i_fill_we, 0);
      check($sformatf("abort c%0d busy", c), bus.busy, 0);
    end
    bus.i_req = 1; bus.i_addr = 16'h0340;
    run_fill(1'b0, 16'h0340);

    // top block: no wrap past 0xFFFE
    bus.d_req = 1; bus.d_addr = 16'hFFFF;
    for (int k = 0; k < WORDS; k++) exp_q.push_back(exp_rd(16'hFFF0 + 16'(2 * k)));
    for (int c = 1; c <= DONE_C + 1; c++) begin
      @(negedge clk);
      if (c == 1) check("top first addr", bus.mem_addr, 16'hFFF0);
      if (c == 8) check("top last addr",  bus.mem_addr, 16'hFFFE);
      fill_cycle_checks(1'b1, 16'hFFFF, c);
      if (c == DONE_C) bus.d_req = 0;
    end

    check("final exp_q empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer for the single-ported, multi-cycle unified memory shared by the instruction-fetch and data-access paths of the pipelined 16-bit CPU. Accepts I-cache and D-cache block-fill requests (8 words, 16 bytes) and D-side single-word write-through stores, grants one at a time by fixed priority, and drives the memory's pipelined read port. Returned words are steered to the granted cache with a word index and write enable. Sits between the two caches and the memory model in the memory stage of the cpu top level.

## Interface
- MEM_LAT, 4, cycles from a read-issue cycle to the matching mem_valid cycle (≥1)
- WORDS, 8, 16-bit words per cache block (power of two; index width log2(WORDS))
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  I-cache fill request, held high until i_done
- i_addr  in  16  I-side miss byte address; low 4 bits ignored
- d_req  in  1  D-cache fill request, held high until d_done
- d_addr  in  16  D-side miss byte address; low 4 bits ignored
- d_wr_req  in  1  write-through store request, held until d_wr_ack
- d_wr_addr  in  16  store byte address
- d_wr_data  in  16  store data
- mem_en  out  1  memory access this cycle
- mem_wr  out  1  access is a write
- mem_addr  out  16  memory byte address
- mem_wdata  out  16  write data
- mem_rdata  in  16  read data, valid when mem_valid
- mem_valid  in  1  read data return strobe
- fill_data  out  16  equals mem_rdata
- fill_word  out  3  word index of current beat
- i_fill_we  out  1  write fill_data into I-cache line
- d_fill_we  out  1  write fill_data into D-cache line
- i_done  out  1  one-cycle pulse, I fill complete
- d_done  out  1  one-cycle pulse, D fill complete
- d_wr_ack  out  1  one-cycle pulse, store performed
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, WRITE, FILL, DONE. Registers: state, owner (I/D), base[15:4], issue_cnt, recv_cnt.
- IDLE grant priority: d_wr_req > d_req > i_req. D side wins because it belongs to the older instruction. The pipeline stalls while any request is pending, so I cannot starve.
- IDLE→WRITE on d_wr_req. In WRITE: mem_en=1, mem_wr=1, mem_addr=d_wr_addr, mem_wdata=d_wr_data, d_wr_ack=1. Next state is IDLE.
- IDLE→FILL on d_req or i_req. Latch owner and base = addr[15:4]. Clear both counters.
- FILL issue: while issue_cnt<WORDS, drive mem_en=1, mem_wr=0, mem_addr={base,issue_cnt,1'b0}. Increment issue_cnt every cycle. Issue is back-to-back with no bubbles.
- FILL receive: on mem_valid, assert {owner}_fill_we and set fill_word=recv_cnt, then increment recv_cnt. Data and enable are combinational from mem_valid in the same cycle.
- When the final beat is received (recv_cnt=WORDS-1 with mem_valid), go to DONE. In DONE, pulse {owner}_done and go to IDLE.
- A requester drops its request in the cycle after its done/ack pulse. IDLE samples requests only in IDLE.
- mem_valid outside FILL is ignored: no fill_we is driven.
- Address arithmetic is 16-bit with no carry out of the block. Block 0xFFF0 fills 0xFFF0..0xFFFE.

## Timing
- Reset: state=IDLE, counters=0, owner=I. All outputs 0 except fill_data, which follows mem_rdata.
- rst mid-operation aborts the fill or write. No done/ack pulse is generated. The memory shares rst and discards in-flight reads.
- Store: request sampled in IDLE at cycle 0, write and ack in cycle 1, IDLE in cycle 2. Store occupancy is 2 cycles.
- Fill (owner X): request sampled at cycle 0, issues in cycles 1..WORDS, beats in cycles 1+MEM_LAT..WORDS+MEM_LAT, X_done at cycle WORDS+MEM_LAT+1. Default case: done at cycle 13, IDLE at cycle 14.
- Simultaneous i_req and d_req: D is served first. I is granted in the IDLE cycle right after d_done.
- Only one mem_en source is active per cycle. mem_wr=1 only in WRITE.

## Test plan
- Single I fill, i_addr=0x012A, memory word at a = a^0x5A5A → issues at 0x0120..0x012E in cycles 1–8; i_fill_we beats with fill_word 0..7 and data 0x5B7A..0x5B74 in cycles 5–12; i_done in cycle 13 only; d_fill_we never asserted.
- i_req and d_req raised together (d_addr=0x4000) → D fill runs first with d_done at cycle 13; I fill is granted at IDLE cycle 14; i_done arrives at cycle 27.
- d_wr_req (addr 0x0010, data 0xBEEF) concurrent with d_req → WRITE in cycle 1 (mem_wr=1, ack) and D fill granted in cycle 2; a later read of 0x0010 returns 0xBEEF.
- rst asserted in cycle 7 of a fill → cycle 8 shows IDLE with all outputs 0 and no done; a fresh i_req completes normally with 8 beats.
- Boundary address d_addr=0xFFFF → issues 0xFFF0..0xFFFE with no wrap to 0x0000.
- mem_valid pulsed while IDLE → no fill_we and no state change.
